serial_subtractor_8bit: RTL and testbench

- Bit-serial subtractor: computes Diff = A - B - Bin, one bit per clock, LSB first.
- Keeps a single borrow flip-flop between bit steps.
- Works in the reverse direction of the parallel 8-bit adder. Used where area matters more than latency, e.g. decrement/compare paths in small datapaths.
- start/busy/done handshake. Result registers hold their value until the next operation completes.

---
 rtl/serial_subtractor_8bit_if.sv | 46 ++++
 rtl/serial_subtractor_8bit.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_8bit_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8bit_if
// Handshake/operand bundle for the bit-serial subtractor.
//   start : request a new operation (requester -> subtractor)
//   A, B  : minuend / subtrahend, sampled on the accepted start cycle
//   Bin   : borrow-in, sampled on the accepted start cycle
//   Diff  : registered difference (A - B - Bin) mod 2^WIDTH
//   Bout  : registered borrow-out
//   busy  : high while the subtraction is running
//   done  : one-cycle pulse when Diff/Bout have been updated
// Modports: master = requester side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output A,
        output B,
        output Bin,
        input  Diff,
        input  Bout,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Bin,
        output Diff,
        output Bout,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8bit
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// with a single borrow flip-flop carried between bit steps.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : serial_subtractor_8bit_if.slave (start/A/B/Bin in,
//          Diff/Bout/busy/done out)
//
// Timing: start accepted in IDLE at edge E0; busy for WIDTH cycles; done
// pulses for one cycle after edge E0+WIDTH, when Diff/Bout are committed.
// Diff/Bout hold their value until the next operation completes.
// -----------------------------------------------------------------------------
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_subtractor_8bit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    // Full-subtractor borrow: set when a < b + bi for single bits.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~a & bi) | (b & bi);
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;

    logic [WIDTH-1:0]   shift_a_r;
    logic [WIDTH-1:0]   shift_b_r;
    logic [WIDTH-1:0]   shift_d_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;

    logic [WIDTH-1:0]   shift_a_nxt_s;
    logic [WIDTH-1:0]   shift_b_nxt_s;
    logic [WIDTH-1:0]   shift_d_nxt_s;
    logic               borrow_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [WIDTH-1:0]   diff_nxt_s;
    logic               bout_nxt_s;

    logic               d_bit_s;
    logic               borrow_step_s;
    logic [WIDTH-1:0]   shift_d_step_s;

    // Next-state, datapath step and result commit decode.
    always_comb begin
        state_nxt_s    = state_r;
        shift_a_nxt_s  = shift_a_r;
        shift_b_nxt_s  = shift_b_r;
        shift_d_nxt_s  = shift_d_r;
        borrow_nxt_s   = borrow_r;
        cnt_nxt_s      = cnt_r;
        diff_nxt_s     = diff_r;
        bout_nxt_s     = bout_r;

        d_bit_s        = fs_diff(shift_a_r[0], shift_b_r[0], borrow_r);
        borrow_step_s  = fs_borrow(shift_a_r[0], shift_b_r[0], borrow_r);
        // The new bit enters at the MSB so that after WIDTH steps the
        // LSB-first stream sits in natural bit order.
        shift_d_step_s = {d_bit_s, shift_d_r[WIDTH-1:1]};

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s   = ST_RUN;
                    shift_a_nxt_s = bus.A;
                    shift_b_nxt_s = bus.B;
                    borrow_nxt_s  = bus.Bin;
                    cnt_nxt_s     = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_a_nxt_s = {1'b0, shift_a_r[WIDTH-1:1]};
                shift_b_nxt_s = {1'b0, shift_b_r[WIDTH-1:1]};
                shift_d_nxt_s = shift_d_step_s;
                borrow_nxt_s  = borrow_step_s;
                cnt_nxt_s     = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    // Last bit: commit the result including this step's bit.
                    state_nxt_s = ST_DONE;
                    diff_nxt_s  = shift_d_step_s;
                    bout_nxt_s  = borrow_step_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // start seen here is deliberately ignored.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shifters, borrow FF, bit counter and committed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a_r <= {WIDTH{1'b0}};
            shift_b_r <= {WIDTH{1'b0}};
            shift_d_r <= {WIDTH{1'b0}};
            borrow_r  <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            diff_r    <= {WIDTH{1'b0}};
            bout_r    <= 1'b0;
        end else begin
            shift_a_r <= shift_a_nxt_s;
            shift_b_r <= shift_b_nxt_s;
            shift_d_r <= shift_d_nxt_s;
            borrow_r  <= borrow_nxt_s;
            cnt_r     <= cnt_nxt_s;
            diff_r    <= diff_nxt_s;
            bout_r    <= bout_nxt_s;
        end
    end

    // busy/done are Moore decodes of the state register.
    assign bus.Diff = diff_r;
    assign bus.Bout = bout_r;
    assign bus.busy = (state_r == ST_RUN);
    assign bus.done = (state_r == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_8bit
// Self-checking bench for serial_subtractor_8bit: directed vector table,
// handshake/throughput sequence, mid-run reset, and random operations.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_8bit;

    logic clk;
    logic rst;

    serial_subtractor_8bit_if #(.WIDTH(8)) sif ();

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Result expected to be on Diff/Bout before the current operation ends.
    logic [7:0] last_d  = 8'h00;
    logic       last_bo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One complete operation; returns result, busy-cycle count, start->done latency,
    // and whether Diff/Bout held the previous result until done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output logic [7:0] d, output logic bo,
                          output int busy_cnt, output int lat, output bit stable);
        @(negedge clk);
        sif.A = a; sif.B = b; sif.Bin = bi; sif.start = 1'b1;
        @(negedge clk);
        // Scramble operands: must not affect the operation in flight.
        sif.start = 1'b0; sif.A = ~a; sif.B = ~b; sif.Bin = ~bi;
        lat = 1; busy_cnt = 0; stable = 1'b1;
        while (!sif.done && lat < 20) begin
            if (sif.busy) busy_cnt++;
            if (sif.Diff !== last_d || sif.Bout !== last_bo) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        d  = sif.Diff;
        bo = sif.Bout;
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0] d;
        logic       bo;
        int         bc, lat;
        bit         stable;
        logic [7:0] ha[30];
        logic [7:0] hb[30];
        logic       hbi[30];
        logic [8:0] expv;
        int         done_seen;

        vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h55, 8'h0A, 1'b0, 8'h4B, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[8] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[9] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0};

        sif.start = 1'b0; sif.A = 8'h00; sif.B = 8'h00; sif.Bin = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_diff", {24'h0, sif.Diff}, 32'h0);
        check("reset_bout", {31'h0, sif.Bout}, 32'h0);
        check("reset_busy", {31'h0, sif.busy}, 32'h0);
        check("reset_done", {31'h0, sif.done}, 32'h0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, bc, lat, stable);
            check($sformatf("vec%0d_diff", i), {24'h0, d}, {24'h0, vecs[i].exp_diff});
            check($sformatf("vec%0d_bout", i), {31'h0, bo}, {31'h0, vecs[i].exp_bout});
            check($sformatf("vec%0d_busy_cycles", i), bc, 8);
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_hold", i), {31'h0, stable}, 32'h1);
            last_d = vecs[i].exp_diff; last_bo = vecs[i].exp_bout;
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {31'h0, sif.done}, 32'h0);
            check($sformatf("vec%0d_idle_hold", i), {23'h0, sif.Bout, sif.Diff},
                  {23'h0, last_bo, last_d});
        end

        // Handshake: start held for 30 cycles, operands changing every cycle.
        // First accept at edge 0, then every 10 edges.
        for (int i = 0; i < 30; i++) begin
            ha[i] = 8'($urandom); hb[i] = 8'($urandom); hbi[i] = 1'($urandom);
            sif.A = ha[i]; sif.B = hb[i]; sif.Bin = hbi[i]; sif.start = 1'b1;
            @(negedge clk);
            check($sformatf("hs%0d_busy", i), {31'h0, sif.busy}, {31'h0, ((i % 10) < 8)});
            check($sformatf("hs%0d_done", i), {31'h0, sif.done}, {31'h0, ((i % 10) == 8)});
            if ((i % 10) == 8) begin
                expv = {1'b0, ha[i-8]} - {1'b0, hb[i-8]} - {8'h00, hbi[i-8]};
                check($sformatf("hs%0d_result", i), {23'h0, sif.Bout, sif.Diff}, {23'h0, expv});
                last_d = expv[7:0]; last_bo = expv[8];
            end else begin
                check($sformatf("hs%0d_hold", i), {23'h0, sif.Bout, sif.Diff},
                      {23'h0, last_bo, last_d});
            end
        end
        sif.start = 1'b0;
        @(negedge clk);

        // Reset mid-run: make sure a nonzero result is present first.
        run_op(8'h50, 8'h20, 1'b0, d, bo, bc, lat, stable);
        check("pre_rst_diff", {24'h0, d}, 32'h30);
        @(negedge clk);
        sif.A = 8'h55; sif.B = 8'h0A; sif.Bin = 1'b0; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy_before_rst", {31'h0, sif.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_diff", {24'h0, sif.Diff}, 32'h0);
        check("rst_async_bout", {31'h0, sif.Bout}, 32'h0);
        check("rst_async_busy", {31'h0, sif.busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sif.done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        last_d = 8'h00; last_bo = 1'b0;
        run_op(8'h55, 8'h0A, 1'b0, d, bo, bc, lat, stable);
        check("post_rst_diff", {24'h0, d}, 32'h4B);
        check("post_rst_bout", {31'h0, bo}, 32'h0);
        check("post_rst_hold", {31'h0, stable}, 32'h1);
        last_d = 8'h4B; last_bo = 1'b0;

        // Random operations.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            expv = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
            run_op(ra, rb, rbi, d, bo, bc, lat, stable);
            check($sformatf("rnd%0d_result", i), {23'h0, bo, d}, {23'h0, expv});
            check($sformatf("rnd%0d_hold", i), {31'h0, stable}, 32'h1);
            last_d = expv[7:0]; last_bo = expv[8];
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
